// File: rtl/gru_pkg.sv
// Shared types and helpers for the GRU gate MAC: activation codes, FSM states,
// clog2 and a signed saturation helper.
package gru_pkg;

  localparam logic [1:0] ACT_NONE = 2'd0;
  localparam logic [1:0] ACT_SIG  = 2'd1;
  localparam logic [1:0] ACT_TANH = 2'd2;

  typedef enum logic [2:0] {IDLE, MAC_X, MAC_H, FIN, ACT, DONE} gru_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Clip a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/gru_gate_act.sv
// Piecewise-linear activation shared by sigmoid (r, z) and candidate (tanh) gates.
// Purely combinational; the caller registers the output.
module gate_act_pwl import gru_pkg::*; #(
  parameter int DATABIT = 16,
  parameter int FRAC    = 8
) (
  input  logic [1:0]                mode,
  input  logic signed [DATABIT-1:0] p,
  output logic signed [DATABIT-1:0] y
);
  localparam int W1 = DATABIT + 1;
  localparam logic signed [DATABIT:0] Q1   = W1'(1 << FRAC);
  localparam logic signed [DATABIT:0] HALF = W1'(1 << (FRAC - 1));

  logic signed [DATABIT:0] pw, sg;

  // One guard bit so (p>>>2)+half cannot wrap before clamping.
  always_comb begin
    pw = W1'(p);
    sg = (pw >>> 2) + HALF;
    y  = p;
    case (mode)
      ACT_NONE: y = p;
      ACT_SIG: begin
        if (sg < 0)       y = '0;
        else if (sg > Q1) y = DATABIT'(Q1);
        else              y = DATABIT'(sg);
      end
      ACT_TANH: begin
        if (pw > Q1)       y = DATABIT'(Q1);
        else if (pw < -Q1) y = DATABIT'(-Q1);
        else               y = p;
      end
      default: y = p;
    endcase
  end

endmodule

// File: rtl/gru_gate_mac.sv
// One GRU gate/cell: act(wx.xt + wh.ht1 + bias) using LANES multipliers
// time-multiplexed over both vectors, then saturation and activation.
module gru_gate_mac import gru_pkg::*; #(
  parameter int INPUTDIMEN = 4,
  parameter int CELLNUM    = 4,
  parameter int DATABIT    = 16,
  parameter int FRAC       = 8,
  parameter int LANES      = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [1:0]                      mode,
  input  logic [INPUTDIMEN*DATABIT-1:0]   xt,
  input  logic [CELLNUM*DATABIT-1:0]      ht1,
  input  logic [INPUTDIMEN*DATABIT-1:0]   wx,
  input  logic [CELLNUM*DATABIT-1:0]      wh,
  input  logic [DATABIT-1:0]              bias,
  output logic                            busy,
  output logic [DATABIT-1:0]              result,
  output logic                            result_sat,
  output logic                            result_valid,
  input  logic                            result_ready
);
  localparam int NX     = (INPUTDIMEN + LANES - 1) / LANES;
  localparam int NH     = (CELLNUM + LANES - 1) / LANES;
  localparam int NMAX   = (NX > NH) ? NX : NH;
  localparam int BW     = clog2(NMAX + 1);
  localparam int ACCBIT = 2 * DATABIT + clog2(INPUTDIMEN + CELLNUM + 1);
  localparam int SW     = ACCBIT + 1;
  localparam int PW     = 2 * DATABIT;

  gru_state_e                     state_q, state_d;
  logic [BW-1:0]                  beat_q, beat_d;
  logic signed [ACCBIT-1:0]       acc_q, acc_d;
  logic [INPUTDIMEN*DATABIT-1:0]  xt_q, xt_d, wx_q, wx_d;
  logic [CELLNUM*DATABIT-1:0]     ht1_q, ht1_d, wh_q, wh_d;
  logic signed [DATABIT-1:0]      bias_q, bias_d;
  logic [1:0]                     mode_q, mode_d;
  logic signed [DATABIT-1:0]      pre_q, pre_d;
  logic                           pre_sat_q, pre_sat_d;
  logic [DATABIT-1:0]             result_q, result_d;
  logic                           sat_q, sat_d;
  logic                           valid_q, valid_d;
  logic                           busy_q, busy_d;

  logic [LANES-1:0][PW-1:0]       prod;
  logic signed [ACCBIT-1:0]       lane_sum;
  logic signed [SW-1:0]           fin_sum, fin_shr;
  logic signed [63:0]             fin_wide, fin_clip;
  logic signed [DATABIT-1:0]      act_y;

  // Lane l handles element beat*LANES+l; lanes past the vector end yield 0.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DATABIT-1:0] a, b;
    int k;
    always_comb begin
      a = '0;
      b = '0;
      k = int'(beat_q) * LANES + l;
      if (state_q == MAC_X && k < INPUTDIMEN) begin
        a = $signed(wx_q[k*DATABIT +: DATABIT]);
        b = $signed(xt_q[k*DATABIT +: DATABIT]);
      end else if (state_q == MAC_H && k < CELLNUM) begin
        a = $signed(wh_q[k*DATABIT +: DATABIT]);
        b = $signed(ht1_q[k*DATABIT +: DATABIT]);
      end
    end
    assign prod[l] = PW'(a) * PW'(b);
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) lane_sum = lane_sum + ACCBIT'($signed(prod[l]));
  end

  gate_act_pwl #(.DATABIT(DATABIT), .FRAC(FRAC)) u_act (
    .mode (mode_q),
    .p    (pre_q),
    .y    (act_y)
  );

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    acc_d     = acc_q;
    xt_d      = xt_q;
    wx_d      = wx_q;
    ht1_d     = ht1_q;
    wh_d      = wh_q;
    bias_d    = bias_q;
    mode_d    = mode_q;
    pre_d     = pre_q;
    pre_sat_d = pre_sat_q;
    result_d  = result_q;
    sat_d     = sat_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    // Bias is aligned to the product scale (2*FRAC) before the single rescale.
    fin_sum   = SW'(acc_q) + (SW'(bias_q) <<< FRAC);
    fin_shr   = fin_sum >>> FRAC;
    fin_wide  = 64'(fin_shr);
    fin_clip  = sat_clip(fin_wide, DATABIT);
    case (state_q)
      IDLE: if (start && !busy_q) begin
        xt_d    = xt;
        wx_d    = wx;
        ht1_d   = ht1;
        wh_d    = wh;
        bias_d  = $signed(bias);
        mode_d  = mode;
        acc_d   = '0;
        beat_d  = '0;
        busy_d  = 1'b1;
        state_d = MAC_X;
      end
      MAC_X: begin
        acc_d = acc_q + lane_sum;
        if (beat_q == BW'(NX - 1)) begin
          beat_d  = '0;
          state_d = MAC_H;
        end else beat_d = beat_q + BW'(1);
      end
      MAC_H: begin
        acc_d = acc_q + lane_sum;
        if (beat_q == BW'(NH - 1)) begin
          beat_d  = '0;
          state_d = FIN;
        end else beat_d = beat_q + BW'(1);
      end
      FIN: begin
        pre_d     = DATABIT'(fin_clip);
        pre_sat_d = (fin_clip != fin_wide);
        state_d   = ACT;
      end
      ACT: begin
        result_d = act_y;
        sat_d    = pre_sat_q;
        valid_d  = 1'b1;
        state_d  = DONE;
      end
      DONE: if (result_ready) begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      acc_q     <= '0;
      xt_q      <= '0;
      wx_q      <= '0;
      ht1_q     <= '0;
      wh_q      <= '0;
      bias_q    <= '0;
      mode_q    <= '0;
      pre_q     <= '0;
      pre_sat_q <= 1'b0;
      result_q  <= '0;
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      acc_q     <= acc_d;
      xt_q      <= xt_d;
      wx_q      <= wx_d;
      ht1_q     <= ht1_d;
      wh_q      <= wh_d;
      bias_q    <= bias_d;
      mode_q    <= mode_d;
      pre_q     <= pre_d;
      pre_sat_q <= pre_sat_d;
      result_q  <= result_d;
      sat_q     <= sat_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign busy         = busy_q;
  assign result       = result_q;
  assign result_sat   = sat_q;
  assign result_valid = valid_q;

endmodule
